// File: rtl/bcd_multidigit_counter.sv
// Multi-digit BCD up/down counter with parallel load, cascade terminal count and sticky wrap flag.
// The whole digit chain resolves in one cycle; there is no ripple between decades.
module bcd_multidigit_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned W      = 4 * DIGITS
) (
  input  logic         CP,
  input  logic         rst,
  input  logic         EN,
  input  logic         Ad,
  input  logic         UP,
  input  logic         LD,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         OV
);

  logic [W-1:0] q_q, q_d;
  logic         ov_q, ov_d;
  logic [W-1:0] step_val;
  logic [W-1:0] load_val;
  logic         carry;
  logic         all9;
  logic         all0;
  logic         run;
  logic [3:0]   dig;
  logic [3:0]   nxt;

  assign run = EN | Ad;

  // carry doubles as borrow when counting down; it survives the top digit only on a wrap
  always_comb begin
    step_val = '0;
    load_val = '0;
    carry    = 1'b1;
    all9     = 1'b1;
    all0     = 1'b1;
    dig      = 4'd0;
    nxt      = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = q_q[4*k +: 4];
      if (dig != 4'd9) all9 = 1'b0;
      if (dig != 4'd0) all0 = 1'b0;
      load_val[4*k +: 4] = (D[4*k +: 4] > 4'd9) ? 4'd9 : D[4*k +: 4];
      nxt = dig;
      if (carry) begin
        if (UP) begin
          if (dig >= 4'd9) begin
            nxt = 4'd0;
          end else begin
            nxt   = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            nxt = 4'd9;
          end else begin
            nxt   = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
      step_val[4*k +: 4] = nxt;
    end
  end

  always_comb begin
    q_d  = q_q;
    ov_d = ov_q;
    if (LD) begin
      q_d  = load_val;
      ov_d = 1'b0;
    end else if (run) begin
      q_d = step_val;
      if (carry) ov_d = 1'b1;
    end
  end

  always_ff @(posedge CP or posedge rst) begin
    if (rst) begin
      q_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      ov_q <= ov_d;
    end
  end

  assign Q  = q_q;
  assign OV = ov_q;
  assign TC = run & (UP ? all9 : all0);

endmodule
